// File: rtl/rf_wb_queue_pkg.sv
// Shared defaults and the entry record for the register-file write-back queue.
package rf_wb_queue_pkg;

   localparam int unsigned WBQ_DEPTH  = 4;
   localparam int unsigned WBQ_REG_W  = 3;
   localparam int unsigned WBQ_DATA_W = 16;

   // One queued register write at the default widths.
   typedef struct packed {
      logic                  valid;
      logic [WBQ_REG_W-1:0]  regsel;
      logic [WBQ_DATA_W-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/rf_wb_queue_match.sv
// Age-priority lookup: the youngest valid entry whose regsel equals sel supplies the data.
module wbq_match
   import rf_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = WBQ_DEPTH,
   parameter int unsigned REG_W  = WBQ_REG_W,
   parameter int unsigned DATA_W = WBQ_DATA_W
) (
   input  logic                       valid  [DEPTH],
   input  logic [REG_W-1:0]           regsel [DEPTH],
   input  logic [DATA_W-1:0]          data   [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   head,
   input  logic [REG_W-1:0]           sel,
   output logic                       hit,
   output logic [DATA_W-1:0]          fwd
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] idx;

   // Walk from oldest (head) to youngest; later matches overwrite earlier ones.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (valid[idx] && (regsel[idx] == sel)) begin
            hit = 1'b1;
            fwd = data[idx];
         end
      end
   end

endmodule

// File: rtl/rf_wb_queue.sv
// In-order write-back queue in front of the register-file write port, with read-port forwarding.
module rf_wb_queue
   import rf_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = WBQ_DEPTH,
   parameter int unsigned REG_W  = WBQ_REG_W,
   parameter int unsigned DATA_W = WBQ_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [REG_W-1:0]         in_regsel,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   input  logic                     hold,
   output logic                     write,
   output logic [REG_W-1:0]         writeregsel,
   output logic [DATA_W-1:0]        writedata,
   input  logic [REG_W-1:0]         read1regsel,
   input  logic [REG_W-1:0]         read2regsel,
   output logic                     hit1,
   output logic [DATA_W-1:0]        fwd1data,
   output logic                     hit2,
   output logic [DATA_W-1:0]        fwd2data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic              valid_q  [DEPTH];
   logic [REG_W-1:0]  regsel_q [DEPTH];
   logic [DATA_W-1:0] data_q   [DEPTH];

   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q, count_d;
   logic          err_q;

   logic empty, full, push, pop;

   // Handshake and drain decisions; in_ready deliberately ignores a same-cycle pop.
   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == CW'(DEPTH));
      push  = in_valid & ~full;
      pop   = ~empty & ~hold;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy, valid bits and overflow pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= in_valid & full;
         // Push and pop never target the same slot: pop needs non-empty, push needs non-full.
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PW'(1);
         end
         if (push) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PW'(1);
         end
      end
   end

   // Payload storage; qualified by valid_q so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         regsel_q[tail_q] <= in_regsel;
         data_q[tail_q]   <= in_data;
      end
   end

   // Write port driven from the head entry only; no path from in_valid.
   always_comb begin
      write       = pop;
      writeregsel = empty ? '0 : regsel_q[head_q];
      writedata   = empty ? '0 : data_q[head_q];
      in_ready    = ~full;
      count       = count_q;
      err         = err_q;
   end

   wbq_match #(
      .DEPTH  (DEPTH),
      .REG_W  (REG_W),
      .DATA_W (DATA_W)
   ) u_match1 (
      .valid  (valid_q),
      .regsel (regsel_q),
      .data   (data_q),
      .head   (head_q),
      .sel    (read1regsel),
      .hit    (hit1),
      .fwd    (fwd1data)
   );

   wbq_match #(
      .DEPTH  (DEPTH),
      .REG_W  (REG_W),
      .DATA_W (DATA_W)
   ) u_match2 (
      .valid  (valid_q),
      .regsel (regsel_q),
      .data   (data_q),
      .head   (head_q),
      .sel    (read2regsel),
      .hit    (hit2),
      .fwd    (fwd2data)
   );

endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Write-back queue feeding the write port of the 8×16 register file. It accepts register-write requests from the pipeline and buffers up to DEPTH of them in order. It drains one per cycle into the register file's write port (`write`, `writeregsel`, `writedata`). It also answers two read-port lookups with the youngest queued value for a register, so a reader never sees a stale value while a write is still pending.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2
- REG_W, 3: register select width
- DATA_W, 16: data width

Ports:
- clk  in  1  system clock; everything on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  write request present
- in_regsel  in  REG_W  destination register of request
- in_data  in  DATA_W  value of request
- in_ready  out  1  queue can accept (not full)
- hold  in  1  suppress drain this cycle
- write  out  1  register-file write enable
- writeregsel  out  REG_W  register-file write select
- writedata  out  DATA_W  register-file write data
- read1regsel  in  REG_W  lookup select, port 1
- read2regsel  in  REG_W  lookup select, port 2
- hit1  out  1  read1regsel has a queued write
- fwd1data  out  DATA_W  youngest queued value for read1regsel
- hit2  out  1  read2regsel has a queued write
- fwd2data  out  DATA_W  youngest queued value for read2regsel
- count  out  $clog2(DEPTH)+1  occupancy
- err  out  1  overflow flag, one-cycle pulse

## Operation
- Storage is a circular buffer of {valid, regsel, data} with head/tail pointers. The pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `in_ready = (count != DEPTH)`. It is independent of drain, so a full queue with a simultaneous pop still refuses the push.
- Push occurs when `in_valid & in_ready`. The entry is written at the tail and the tail advances.
- Pop occurs when `!empty & !hold`. The head advances at the edge.
- Write port is combinational from the head entry:
  - `write = !empty & !hold`
  - `writeregsel`/`writedata` = head fields; 0 when empty
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Lookup compares each valid entry's regsel with readNregsel.
  - `hitN` = any match.
  - `fwdNdata` = data of the youngest match (closest to tail); 0 if no hit.
  - Priority is by age from head, not by physical index.
- Multiple queued writes to one register are all drained in order; lookup always returns the last one.
- Overflow: `in_valid & !in_ready` drops the request and sets err on the next cycle for one cycle. It is not sticky.
- Reset (asynchronous, any time, including mid-drain):
  - pointers, count, all valid bits and err go to 0
  - write=0, in_ready=1, hit1=hit2=0
  - queued writes are discarded

## Timing
- Push accepted at edge N: entry drives the write port in cycle N+1 and reaches the register file at edge N+1, if hold is low.
- Lookup hit is visible from cycle N+1 until the cycle the entry is the head being written. The register file's own same-cycle bypass covers that cycle, so a consumer sees the value at all times.
- Throughput: one push and one pop per cycle sustained.
- No combinational path from in_valid to write; a same-cycle pass-through is not allowed.
- hold high for K cycles stalls the drain K cycles. Pushes continue until full.

## Structure
- Shared package holds REG_W, DATA_W, DEPTH defaults and the entry record {valid, regsel, data}.
- One sub-module, `wbq_match`, instantiated twice:
  - inputs: entry array, head pointer, select
  - outputs: age-priority hit and data

## Test plan
- **Reset, then idle:**
  - write=0, in_ready=1, count=0, err=0, hit1=hit2=0.
- **Single push, then drain:**
  - Stimulus: push (r3, 0xBEEF) at edge 1.
  - Cycle 1: write=1, writeregsel=3, writedata=0xBEEF; hit1=1 with read1regsel=3.
  - After edge 2: count=0 and write=0.
- **Fill and overflow:**
  - Stimulus: hold=1, push r0..r3; then a fifth push (r5, 0x5555).
  - in_ready=0 at count=4; fifth push dropped; err=1 for exactly one cycle; count stays 4.
  - Release hold: writes r0..r3 appear on consecutive cycles.
- **Same-register priority:**
  - Stimulus: hold=1, push (r2, 0x1111) then (r2, 0x2222).
  - fwd1data=0x2222 with read1regsel=2.
  - After first pop: still 0x2222. After second pop: hit1=0.
- **Wrap-around with simultaneous push/pop:**
  - Stimulus: 10 cycles of continuous push (ri mod 8, data=i) with hold=0.
  - count stays 1; write data sequence is 0..9 with no gaps.
- **Async reset mid-operation:**
  - Stimulus: rst raised between edges with count=3.
  - write, hit1 and hit2 drop immediately, before the next edge; after release, count=0 and in_ready=1.
